vproc_div_seq: RTL and testbench
================================

// Module: vproc_div_seq
// PURPOSE
//  Sequencer for the shared 17-bit element divider (vproc_div_block). Accepts one packed request of
//  ELEM_CNT 16-bit elements, issues one element per cycle to the divider, and handles signedness and
//  the RISC-V divide-by-zero and overflow cases. It collects the pipelined results and returns them as one packed word.
//  Sits between the vector ELEM unit issue logic and the divider instance.
// PARAMETERS
//  ELEM_CNT  4  number of 16-bit elements per request (>=1)
//  DIV_LAT   0  divider latency in cycles (= BUF_OPS+BUF_DIV+BUF_RES of the divider instance, 0..3)
// PORTS
//  clk_i         in   1            clock
//  async_rst_ni  in   1            asynchronous active-low reset
//  req_valid_i   in   1            request valid
//  req_ready_o   out  1            request ready (high only in IDLE)
//  req_op1_i     in   ELEM_CNT*16  dividends; element i = bits [16*i+15:16*i]
//  req_op2_i     in   ELEM_CNT*16  divisors, same packing
//  req_signed_i  in   1            1 = signed (div/rem), 0 = unsigned (divu/remu)
//  req_mod_i     in   1            0 = quotient, 1 = remainder
//  res_valid_o   out  1            result valid
//  res_ready_i   in   1            result accepted
//  res_o         out  ELEM_CNT*16  packed results, same packing
//  div_mod_o     out  1            mod select to divider
//  div_op1_o     out  17           unsigned dividend magnitude to divider
//  div_op2_o     out  17           unsigned divisor magnitude to divider
//  div_res_i     in   33           divider result; bits [15:0] used
// BEHAVIOUR
//  - Reset: state=IDLE, res_valid_o=0, res_o=0, all in-flight tags cleared, div_op*_o=0, div_mod_o=0.
//  - Reset mid-operation discards everything. Divider internal registers are not reset; stale data is never captured because tags are cleared.
//  - FSM: IDLE -> ISSUE on req_valid_i (acceptance edge E0). Operands, signed and mod are latched at E0.
//  - ISSUE: element i is driven during cycle i after E0 (i=0..ELEM_CNT-1). After the last element -> DRAIN if DIV_LAT>0, else -> DONE.
//  - DRAIN: waits for the remaining tags. Goes to DONE on the edge that captures the last element.
//  - DONE: res_valid_o=1; res_o held stable until res_ready_i=1. The handshake edge moves the FSM to IDLE and drops res_valid_o.
//    req_ready_o=0 outside IDLE; no overlap of requests.
//  - Tag pipeline: a DIV_LAT-deep shift register of {valid, idx, neg_q, neg_r, dz, dividend}. The result for element i is
//    captured at edge E(i+1+DIV_LAT). res_valid_o rises ELEM_CNT+DIV_LAT edges after E0.
//    Example: ELEM_CNT=4, DIV_LAT=0 -> res_valid_o high in the cycle after E4.
//  - Divider is never stalled; backpressure only applies in DONE, when nothing is in flight.
//  - div_op*_o=0 when not in ISSUE. div_mod_o = latched mod throughout.
//  - Signed: magnitude = |x| zero-extended to 17b (|-32768| = 32768 fits).
//    Quotient negated if operand signs differ; remainder takes the sign of the dividend. Truncate to 16b.
//  - Unsigned: zero-extend to 17b, no sign fix-up.
//  - Divide by zero (op2==0, any signedness): the divider output is ignored.
//    Quotient = 16'hFFFF, remainder = dividend.
//  - Overflow (signed, -32768 / -1): quotient 16'h8000, remainder 0 (falls out of the magnitude path; must hold).
//  - req_valid_i while not IDLE is ignored (no acceptance).
// TESTING
//  1. Unsigned div, DIV_LAT=0. op1={0,65535,7,100}, op2={5,256,7,7} (elem3..0).
//     -> res_o={0,255,1,14}; res_valid_o exactly 4 edges after acceptance.
//  2. Signed, DIV_LAT=3. -7/2 -> 16'hFFFD; -7%2 -> 16'hFFFF; 7/-2 -> 16'hFFFD; 7%-2 -> 16'h0001. Latency 7 edges.
//  3. Divide by zero. Unsigned and signed 16'h1234/0 -> quotient 16'hFFFF, remainder 16'h1234, with no X on res_o.
//  4. Overflow. Signed 16'h8000 / 16'hFFFF -> quotient 16'h8000, remainder 16'h0000.
//  5. Backpressure. Hold res_ready_i=0 for 10 cycles in DONE -> res_o stable, req_ready_o=0.
//     Release -> back in IDLE next cycle; a new request is accepted and computes correctly.
//  6. Reset mid-ISSUE with DIV_LAT=3 (after 2 elements issued).
//     -> all outputs at reset values; the next request returns only its own results, none stale.

Source files
------------

// File: rtl/vproc_div_seq.sv
// Sequencer for the shared 17-bit element divider: issues one 16-bit element per cycle,
// applies signed/unsigned fix-ups, divide-by-zero and overflow rules, and repacks the results.
module vproc_div_seq #(
    parameter int unsigned ELEM_CNT = 4,
    parameter int unsigned DIV_LAT  = 0
) (
    input  logic                   clk_i,
    input  logic                   async_rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [ELEM_CNT*16-1:0] req_op1_i,
    input  logic [ELEM_CNT*16-1:0] req_op2_i,
    input  logic                   req_signed_i,
    input  logic                   req_mod_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [ELEM_CNT*16-1:0] res_o,
    output logic                   div_mod_o,
    output logic [16:0]            div_op1_o,
    output logic [16:0]            div_op2_o,
    input  logic [32:0]            div_res_i
);

    localparam int unsigned   IW       = (ELEM_CNT > 1) ? $clog2(ELEM_CNT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(ELEM_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          neg_q;
        logic          neg_r;
        logic          dz;
        logic [15:0]   dvd;
    } tag_t;

    // |x| as a 17-bit unsigned value; -32768 maps to 32768 without wrapping.
    function automatic logic [16:0] magnitude(input logic [15:0] x, input logic sgn);
        logic signed [16:0] sx;
        sx = {sgn & x[15], x};
        return (sx < 0) ? $unsigned(-sx) : $unsigned(sx);
    endfunction

    function automatic logic [15:0] apply_sign(input logic [15:0] mag, input logic neg);
        return neg ? 16'(~mag + 16'd1) : mag;
    endfunction

    // Divide-by-zero bypasses the divider entirely; the overflow case needs no
    // special handling since 32768/1 truncates to 16'h8000 with remainder 0.
    function automatic logic [15:0] fix_result(input logic [15:0] raw, input tag_t t,
                                               input logic m);
        if (t.dz) begin
            return m ? t.dvd : 16'hFFFF;
        end
        return apply_sign(raw, m ? t.neg_r : t.neg_q);
    endfunction

    state_t                 state_q, state_d;
    logic [IW-1:0]          cnt_q;
    logic                   sgn_q, mod_q;
    logic [ELEM_CNT*16-1:0] op1_q, op2_q, res_q;
    logic                   accept, issue;
    logic [15:0]            cur_a, cur_b;
    tag_t                   cur_tag;
    logic                   cap_vld, last_cap;
    tag_t                   cap_tag;
    logic                   unused_res_hi;

    assign accept = (state_q == IDLE) && req_valid_i;
    assign issue  = (state_q == ISSUE);

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            mod_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
                sgn_q <= req_signed_i;
                mod_q <= req_mod_i;
            end else if (issue) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            op1_q <= req_op1_i;
            op2_q <= req_op2_i;
        end
    end

    // Issue stage (p0): current element and the tag that travels with it.
    assign cur_a = op1_q[16*cnt_q +: 16];
    assign cur_b = op2_q[16*cnt_q +: 16];

    always_comb begin
        cur_tag       = '0;
        cur_tag.idx   = cnt_q;
        cur_tag.neg_q = (sgn_q & cur_a[15]) ^ (sgn_q & cur_b[15]);
        cur_tag.neg_r = sgn_q & cur_a[15];
        cur_tag.dz    = (cur_b == 16'd0);
        cur_tag.dvd   = cur_a;
    end

    assign div_op1_o = issue ? magnitude(cur_a, sgn_q) : '0;
    assign div_op2_o = issue ? magnitude(cur_b, sgn_q) : '0;
    assign div_mod_o = mod_q;

    // Tag delay line matching the divider latency (p1..pN).
    if (DIV_LAT == 0) begin : g_comb
        assign cap_vld = issue;
        assign cap_tag = cur_tag;
    end else begin : g_pipe
        logic vld_p [DIV_LAT];
        tag_t tag_p [DIV_LAT];

        always_ff @(posedge clk_i or negedge async_rst_ni) begin
            if (!async_rst_ni) begin
                for (int i = 0; i < DIV_LAT; i++) begin
                    vld_p[i] <= 1'b0;
                end
            end else begin
                vld_p[0] <= issue;
                for (int i = 1; i < DIV_LAT; i++) begin
                    vld_p[i] <= vld_p[i-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            tag_p[0] <= cur_tag;
            for (int i = 1; i < DIV_LAT; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end

        assign cap_vld = vld_p[DIV_LAT-1];
        assign cap_tag = tag_p[DIV_LAT-1];
    end

    // Capture stage: fix up and place the returning element.
    assign last_cap = cap_vld && (cap_tag.idx == LAST_IDX);

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            res_q <= '0;
        end else if (cap_vld) begin
            res_q[16*cap_tag.idx +: 16] <= fix_result(div_res_i[15:0], cap_tag, mod_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = ISSUE;
            ISSUE:   if (cnt_q == LAST_IDX) state_d = (DIV_LAT == 0) ? DONE : DRAIN;
            DRAIN:   if (last_cap) state_d = DONE;
            DONE:    if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o   = (state_q == IDLE);
    assign res_valid_o   = (state_q == DONE);
    assign res_o         = res_q;
    assign unused_res_hi = ^div_res_i[32:16];

endmodule

// File: tb/tb_vproc_div_seq.sv
// Bench for vproc_div_seq: two instances (DIV_LAT=0 and DIV_LAT=3) each driving a
// behavioural divider; results compared against hand tables and an arithmetic model.
module tb_vproc_div_seq;

    logic        clk;
    logic        async_rst_ni;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [63:0] req_op1    [2];
    logic [63:0] req_op2    [2];
    logic        req_signed [2];
    logic        req_mod    [2];
    logic        res_valid  [2];
    logic        res_ready  [2];
    logic [63:0] res        [2];
    logic        div_mod    [2];
    logic [16:0] div_op1    [2];
    logic [16:0] div_op2    [2];
    logic [32:0] div_res    [2];
    logic [32:0] dpipe      [3];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vproc_div_seq #(.ELEM_CNT(4), .DIV_LAT(0)) u_dut0 (
        .clk_i(clk), .async_rst_ni(async_rst_ni),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_op1_i(req_op1[0]), .req_op2_i(req_op2[0]),
        .req_signed_i(req_signed[0]), .req_mod_i(req_mod[0]),
        .res_valid_o(res_valid[0]), .res_ready_i(res_ready[0]), .res_o(res[0]),
        .div_mod_o(div_mod[0]), .div_op1_o(div_op1[0]), .div_op2_o(div_op2[0]),
        .div_res_i(div_res[0])
    );

    vproc_div_seq #(.ELEM_CNT(4), .DIV_LAT(3)) u_dut3 (
        .clk_i(clk), .async_rst_ni(async_rst_ni),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_op1_i(req_op1[1]), .req_op2_i(req_op2[1]),
        .req_signed_i(req_signed[1]), .req_mod_i(req_mod[1]),
        .res_valid_o(res_valid[1]), .res_ready_i(res_ready[1]), .res_o(res[1]),
        .div_mod_o(div_mod[1]), .div_op1_o(div_op1[1]), .div_op2_o(div_op2[1]),
        .div_res_i(div_res[1])
    );

    // Unsigned divider; garbage on divide-by-zero, no reset on its pipeline.
    function automatic logic [32:0] div_fn(input logic [16:0] a, input logic [16:0] b,
                                           input logic m);
        if (b == 17'd0) return 33'h1_5A5A_A5A5;
        return m ? 33'(a % b) : 33'(a / b);
    endfunction

    assign div_res[0] = div_fn(div_op1[0], div_op2[0], div_mod[0]);
    always @(posedge clk) begin
        dpipe[0] <= div_fn(div_op1[1], div_op2[1], div_mod[1]);
        dpipe[1] <= dpipe[0];
        dpipe[2] <= dpipe[1];
    end
    assign div_res[1] = dpipe[2];

    function automatic logic [15:0] ref_elem(input logic [15:0] a, input logic [15:0] b,
                                             input logic s, input logic m);
        int sa, sb, q, r;
        if (b == 16'd0) return m ? a : 16'hFFFF;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        q  = sa / sb;
        r  = sa % sb;
        return m ? r[15:0] : q[15:0];
    endfunction

    function automatic logic [63:0] ref_word(input logic [63:0] a, input logic [63:0] b,
                                             input logic s, input logic m);
        logic [63:0] w;
        for (int i = 0; i < 4; i++) w[16*i +: 16] = ref_elem(a[16*i +: 16], b[16*i +: 16], s, m);
        return w;
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0001;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_req(input int u, input logic [63:0] a, input logic [63:0] b,
                             input logic s, input logic m);
        req_op1[u]    = a;
        req_op2[u]    = b;
        req_signed[u] = s;
        req_mod[u]    = m;
        req_valid[u]  = 1'b1;
        @(posedge clk);
        #1;
        req_valid[u]  = 1'b0;
    endtask

    task automatic wait_res(input int u, input string name, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (res_valid[u]) break;
        end
        check({name, "_seen"}, 128'(res_valid[u]), 128'd1);
    endtask

    task automatic finish_res(input int u, input string name);
        res_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        res_ready[u] = 1'b0;
        check({name, "_idle"}, {126'd0, res_valid[u], req_ready[u]}, 128'b01);
    endtask

    task automatic do_req(input int u, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic m, input logic [63:0] exp,
                          input int hold, input string name);
        int lat;
        start_req(u, a, b, s, m);
        wait_res(u, name, lat);
        check({name, "_lat"}, 128'(lat), (u == 0) ? 128'd4 : 128'd7);
        check({name, "_res"}, 128'(res[u]), 128'(exp));
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        finish_res(u, name);
    endtask

    task automatic check_reset_outputs(input string name);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s_u%0d_ctl", name, u),
                  {125'd0, req_ready[u], res_valid[u], div_mod[u]}, 128'b100);
            check($sformatf("%s_u%0d_res", name, u), 128'(res[u]), 128'd0);
            check($sformatf("%s_u%0d_ops", name, u), 128'({div_op1[u], div_op2[u]}), 128'd0);
        end
    endtask

    typedef struct {
        int          u;
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic        m;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb, held;
        logic        rs, rm;
        int          lat;

        tbl[0] = '{0, 64'h0000_FFFF_0007_0064, 64'h0005_0100_0007_0007, 1'b0, 1'b0, 64'h0000_00FF_0001_000E};
        tbl[1] = '{1, 64'h8000_0064_0007_FFF9, 64'hFFFF_0007_FFFE_0002, 1'b1, 1'b0, 64'h8000_000E_FFFD_FFFD};
        tbl[2] = '{1, 64'h8000_0064_0007_FFF9, 64'hFFFF_0007_FFFE_0002, 1'b1, 1'b1, 64'h0000_0002_0001_FFFF};
        tbl[3] = '{0, 64'h1234_1234_FFFF_0010, 64'h0000_0000_0000_0003, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_0005};
        tbl[4] = '{0, 64'h1234_1234_FFFF_0010, 64'h0000_0000_0000_0003, 1'b0, 1'b1, 64'h1234_1234_FFFF_0001};
        tbl[5] = '{1, 64'h1234_8000_FFF9_1234, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[6] = '{1, 64'h1234_8000_FFF9_1234, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 64'h1234_8000_FFF9_1234};
        tbl[7] = '{1, 64'hFFFF_8000_0064_FFF9, 64'hFFFF_0001_0007_0002, 1'b0, 1'b0, 64'h0001_8000_000E_7FFC};
        tbl[8] = '{0, 64'h8000_FFFF_7FFF_8000, 64'h0001_FFFF_8000_8000, 1'b1, 1'b0, 64'h8000_0001_0000_0001};
        tbl[9] = '{0, 64'h8000_1234_8000_1234, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b1, 64'h0000_1234_0000_1234};

        async_rst_ni = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_op1[u] = '0; req_op2[u] = '0;
            req_signed[u] = 1'b0; req_mod[u] = 1'b0; res_ready[u] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        async_rst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            do_req(tbl[i].u, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m, tbl[i].exp, 0,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: DONE held for 10 cycles, stray request attempts ignored.
        start_req(1, 64'h0010_FFF0_0064_FF9C, 64'h0003_0003_FFF6_000A, 1'b1, 1'b0);
        wait_res(1, "bp", lat);
        check("bp_lat", 128'(lat), 128'd7);
        check("bp_res", 128'(res[1]), 128'h0005_FFFB_FFF6_FFF6);
        held = res[1];
        for (int c = 0; c < 10; c++) begin
            req_op1[1] = 64'h1111_1111_1111_1111;
            req_valid[1] = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d", c), {62'd0, res[1], res_valid[1], req_ready[1]},
                  {62'd0, held, 1'b1, 1'b0});
        end
        req_valid[1] = 1'b0;
        finish_res(1, "bp");
        do_req(1, 64'h0009_0008_0007_0006, 64'h0002_0002_0002_0002, 1'b0, 1'b1,
               64'h0001_0000_0001_0000, 0, "bp_next");

        // Reset in the middle of ISSUE after two elements; stale divider data must not land.
        start_req(1, 64'h1111_2222_3333_4444, 64'h0000_0000_0007_0005, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        async_rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        async_rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_stale%0d", c), {63'd0, res[1], res_valid[1]}, 128'd0);
        end
        do_req(1, 64'hFF00_0100_8000_7FFF, 64'h0010_FFF0_0002_0010, 1'b1, 1'b0,
               ref_word(64'hFF00_0100_8000_7FFF, 64'h0010_FFF0_0002_0010, 1'b1, 1'b0),
               0, "rst_next");

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 4; i++) begin
                ra[16*i +: 16] = pick16();
                rb[16*i +: 16] = pick16();
            end
            rs = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            do_req(k % 2, ra, rb, rs, rm, ref_word(ra, rb, rs, rm), $urandom_range(0, 3),
                   $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
